// File: rtl/seq_mult4x4.sv
// Sequential unsigned 4x4 multiplier: four 2x2 partial products accumulated one per cycle.
// Latency: done drops for 4 cycles (PP0..PP3) after the start-sampling edge, then the product is valid.
// Backpressure: start is sampled only while done=1; start while busy is ignored, nothing is queued.
// Optional build macro SEQ_MULT_OUTREG_EN adds an output register so out never shows partial sums.

// Combinational 2b x 2b unsigned multiply (max 3*3 = 9).
module mult2x2 (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [3:0] p
);
  // Widen before multiplying so the full 4-bit product is kept.
  always_comb begin
    p = {2'b00, x} * {2'b00, y};
  end
endmodule

module seq_mult4x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       done,
  output logic [7:0] out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PP0  = 3'd1,
    PP1  = 3'd2,
    PP2  = 3'd3,
    PP3  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] acc_q, acc_d;

  // Controller outputs steering the shared datapath.
  logic       a_sel;
  logic       b_sel;
  logic [1:0] sh_sel;
  logic       acc_en;
  logic       acc_clr;

  // Datapath nets.
  logic [1:0] a_half;
  logic [1:0] b_half;
  logic [3:0] pp;
  logic [7:0] pp_sh;

  // Next state and datapath control; operands are captured only when a start is accepted.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    a_sel   = 1'b0;
    b_sel   = 1'b0;
    sh_sel  = 2'd0;
    acc_en  = 1'b0;
    acc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_clr = 1'b1;
          state_d = PP0;
        end
      end
      PP0: begin
        acc_en  = 1'b1;
        state_d = PP1;
      end
      PP1: begin
        b_sel   = 1'b1;
        sh_sel  = 2'd1;
        acc_en  = 1'b1;
        state_d = PP2;
      end
      PP2: begin
        a_sel   = 1'b1;
        sh_sel  = 2'd1;
        acc_en  = 1'b1;
        state_d = PP3;
      end
      PP3: begin
        a_sel   = 1'b1;
        b_sel   = 1'b1;
        sh_sel  = 2'd2;
        acc_en  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand half selection feeding the shared 2x2 core.
  always_comb begin
    a_half = a_sel ? a_q[3:2] : a_q[1:0];
    b_half = b_sel ? b_q[3:2] : b_q[1:0];
  end

  mult2x2 u_mult2x2 (
    .x (a_half),
    .y (b_half),
    .p (pp)
  );

  // Shift mux aligns the partial product to its weight (x1, x4, x16).
  always_comb begin
    case (sh_sel)
      2'd0:    pp_sh = {4'b0000, pp};
      2'd1:    pp_sh = {2'b00, pp, 2'b00};
      2'd2:    pp_sh = {pp, 4'b0000};
      default: pp_sh = 8'h00;
    endcase
  end

  // Accumulator next value: clear on accept, add while busy, hold in IDLE.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = 8'h00;
    end else if (acc_en) begin
      acc_d = acc_q + pp_sh;
    end
  end

  // State, operand and accumulator registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      acc_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Ready / result-valid indication.
  always_comb begin
    done = (state_q == IDLE);
  end

`ifdef SEQ_MULT_OUTREG_EN
  logic [7:0] out_q, out_d;

  // Output register loads only the completed sum, so partial sums stay hidden.
  always_comb begin
    out_d = out_q;
    if (state_q == PP3) begin
      out_d = acc_d;
    end
  end

  // Output register storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= 8'h00;
    end else begin
      out_q <= out_d;
    end
  end

  // Product seen at the port.
  always_comb begin
    out = out_q;
  end
`else
  // Product seen at the port is the live accumulator.
  always_comb begin
    out = acc_q;
  end
`endif

endmodule

// File: tb/tb_seq_mult4x4.sv
// Directed bench for seq_mult4x4: table of operand pairs plus hand-written corner sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honors SEQ_MULT_OUTREG_EN for the checks of out while the unit is busy.

module tb_seq_mult4x4;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       done;
  logic [7:0] out;

  int checks;
  int errors;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  seq_mult4x4 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One isolated operation: start pulse for one cycle, count busy cycles, read product.
  task automatic run_op(input logic [3:0] aa, input logic [3:0] bb, output int low_cnt,
                        output logic done_end, output logic [7:0] out_end);
    @(negedge clk);
    a = aa;
    b = bb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (!done) low_cnt++;
      @(negedge clk);
    end
    done_end = done;
    out_end  = out;
  endtask

  int          lc;
  logic        de;
  logic [7:0]  oe;
  logic [7:0]  prev;
  logic [3:0]  b2b_a[4];
  logic [3:0]  b2b_b[4];
  logic [7:0]  b2b_e[3];

  initial begin
    checks = 0;
    errors = 0;
    start  = 1'b0;
    a      = 4'h0;
    b      = 4'h0;
    rst    = 1'b0;

    vecs[0] = '{a: 4'd8,  b: 4'd3,  exp: 8'd24};
    vecs[1] = '{a: 4'd11, b: 4'd6,  exp: 8'd66};
    vecs[2] = '{a: 4'd5,  b: 4'd13, exp: 8'd65};
    vecs[3] = '{a: 4'd15, b: 4'd15, exp: 8'd225};
    vecs[4] = '{a: 4'd0,  b: 4'd9,  exp: 8'd0};
    vecs[5] = '{a: 4'd1,  b: 4'd1,  exp: 8'd1};
    vecs[6] = '{a: 4'd15, b: 4'd0,  exp: 8'd0};
    vecs[7] = '{a: 4'd10, b: 4'd10, exp: 8'd100};

    // Reset state, before any clock edge.
    #2;
    check("reset_done", {31'd0, done}, 32'd1);
    check("reset_out", {24'd0, out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd1);
    check("idle_out", {24'd0, out}, 32'd0);

    // Table-driven isolated operations.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, lc, de, oe);
      check($sformatf("vec%0d_busy_cycles", i), lc, 32'd4);
      check($sformatf("vec%0d_done", i), {31'd0, de}, 32'd1);
      check($sformatf("vec%0d_out", i), {24'd0, oe}, {24'd0, vecs[i].exp});
    end
    // Result holds while idle with start low.
    repeat (2) @(negedge clk);
    check("hold_done", {31'd0, done}, 32'd1);
    check("hold_out", {24'd0, out}, 32'd100);

    // Start pulse and operand changes during PP1 are ignored: 7*9 = 63.
    @(negedge clk);
    a = 4'd7;
    b = 4'd9;
    start = 1'b1;
    @(negedge clk);            // PP0
    start = 1'b0;
    @(negedge clk);            // PP1
    start = 1'b1;
    a = 4'd2;
    b = 4'd3;
    @(negedge clk);            // PP2
    start = 1'b0;
    check("ign_busy_pp2", {31'd0, done}, 32'd0);
    @(negedge clk);            // PP3
    check("ign_busy_pp3", {31'd0, done}, 32'd0);
    @(negedge clk);            // IDLE
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_out", {24'd0, out}, 32'd63);
    @(negedge clk);
    check("ign_no_requeue", {31'd0, done}, 32'd1);

    // Reset during PP2 aborts immediately; 12*12 = 144 afterwards.
    a = 4'd9;
    b = 4'd9;
    start = 1'b1;
    @(negedge clk);            // PP0
    start = 1'b0;
    @(negedge clk);            // PP1
    @(negedge clk);            // PP2
    check("abort_busy", {31'd0, done}, 32'd0);
    rst = 1'b0;
    #1;
    check("abort_done", {31'd0, done}, 32'd1);
    check("abort_out", {24'd0, out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(4'd12, 4'd12, lc, de, oe);
    check("post_abort_busy_cycles", lc, 32'd4);
    check("post_abort_out", {24'd0, oe}, 32'd144);

    // Start held high: back-to-back ops, operands recaptured on each IDLE visit.
    b2b_a[0] = 4'd3;  b2b_b[0] = 4'd5;  b2b_e[0] = 8'd15;
    b2b_a[1] = 4'd4;  b2b_b[1] = 4'd7;  b2b_e[1] = 8'd28;
    b2b_a[2] = 4'd13; b2b_b[2] = 4'd11; b2b_e[2] = 8'd143;
    b2b_a[3] = 4'd0;  b2b_b[3] = 4'd0;
    prev = 8'd144;
    @(negedge clk);            // IDLE
    a = b2b_a[0];
    b = b2b_b[0];
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);          // PP0
      check($sformatf("b2b%0d_pp0_done", k), {31'd0, done}, 32'd0);
`ifdef SEQ_MULT_OUTREG_EN
      check($sformatf("b2b%0d_pp0_out", k), {24'd0, out}, {24'd0, prev});
`else
      check($sformatf("b2b%0d_pp0_out", k), {24'd0, out}, 32'd0);
`endif
      a = b2b_a[k+1];
      b = b2b_b[k+1];
      for (int j = 1; j < 4; j++) begin
        @(negedge clk);        // PP1..PP3
        check($sformatf("b2b%0d_pp%0d_done", k, j), {31'd0, done}, 32'd0);
`ifdef SEQ_MULT_OUTREG_EN
        check($sformatf("b2b%0d_pp%0d_out", k, j), {24'd0, out}, {24'd0, prev});
`endif
      end
      @(negedge clk);          // IDLE, start still high
      check($sformatf("b2b%0d_done", k), {31'd0, done}, 32'd1);
      check($sformatf("b2b%0d_out", k), {24'd0, out}, {24'd0, b2b_e[k]});
      prev = b2b_e[k];
    end
    start = 1'b0;
    @(negedge clk);
    check("b2b_end_idle", {31'd0, done}, 32'd1);
    check("b2b_end_out", {24'd0, out}, 32'd143);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
